axis_video_sink: RTL and testbench

AXI4-Stream video slave. It is the receiving end of the 24-bit RGB pixel stream, where tuser marks start-of-frame (SOF) and tlast marks end-of-line (EOL).
It accepts beats under a programmable tready back-pressure pattern and re-times each accepted pixel with its x/y coordinates.
It checks framing against the configured geometry and reports sticky errors and a frame counter.
It sits at the downstream end of the video pipeline, ahead of frame buffering and recognition logic, and doubles as the bench sink for stream sources.

---
 rtl/axis_video_pkg.sv | 17 +
 rtl/axis_ready_throttle.sv | 22 ++
 rtl/axis_video_sink.sv | 175 +++++++++++++++++
 tb/tb_axis_video_sink.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pkg.sv
// rtl/axis_video_pkg.sv - shared states, widths and constants for the video sink
package axis_video_pkg;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_SOF = 2'd0;
  localparam state_t ACTIVE   = 2'd1;
  localparam state_t FLUSH    = 2'd2;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Wide enough for any DATA_W up to 128; sliced to the real keep width.
  localparam int MAX_KEEP_W = 16;
  localparam logic [MAX_KEEP_W-1:0] KEEP_ALL_ONES = '1;

endpackage

// File: rtl/axis_ready_throttle.sv
// rtl/axis_ready_throttle.sv - 8-phase pattern generator driving a registered tready
module axis_ready_throttle (
  input  logic       clk,
  input  logic       areset,
  input  logic       en,
  input  logic [7:0] pattern,
  output logic       tready
);

  logic [2:0] phase;

  always_ff @(posedge clk) begin
    if (areset) begin
      phase  <= 3'd0;
      tready <= 1'b0;
    end else begin
      phase  <= phase + 3'd1;
      tready <= en ? pattern[phase] : 1'b1;
    end
  end

endmodule

// File: rtl/axis_video_sink.sv
// rtl/axis_video_sink.sv - AXI4-Stream RGB sink with coordinate tagging and framing checks
module axis_video_sink
  import axis_video_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  input  logic                  throttle_en,
  input  logic [7:0]            throttle_pattern,
  input  logic                  clear,
  output logic                  pix_valid,
  output logic [DATA_W-1:0]     pix_data,
  output logic [CNT_W-1:0]      pix_x,
  output logic [CNT_W-1:0]      pix_y,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  frame_done,
  output logic [COUNT_W-1:0]    frame_count,
  output logic [COUNT_W-1:0]    drop_count,
  output logic                  err_eol_early,
  output logic                  err_eol_late,
  output logic                  err_sof_early,
  output logic                  err_keep
);

  localparam int KEEP_W = DATA_W / 8;
  localparam logic [KEEP_W-1:0] KEEP_FULL = KEEP_ALL_ONES[KEEP_W-1:0];
  localparam logic [CNT_W-1:0]  X_LAST    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  Y_LAST    = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  axis_ready_throttle u_throttle (
    .clk     (aclk),
    .areset  (areset),
    .en      (throttle_en),
    .pattern (throttle_pattern),
    .tready  (s_axis_tready)
  );

  state_t           state, state_n;
  logic [CNT_W-1:0] x, y, x_n, y_n, cx, cy;
  logic             acc, emit, sof, eol, done, drop;
  logic             e_early, e_late, e_sof, e_keep;

  assign acc = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_n = (state == ACTIVE || state == FLUSH) ? state : WAIT_SOF;
    x_n     = x;
    y_n     = y;
    cx      = x;
    cy      = y;
    emit    = 1'b0;
    sof     = 1'b0;
    eol     = 1'b0;
    done    = 1'b0;
    drop    = 1'b0;
    e_early = 1'b0;
    e_late  = 1'b0;
    e_sof   = 1'b0;
    e_keep  = 1'b0;
    if (acc) begin
      e_keep = (s_axis_tkeep != KEEP_FULL);
      // SOF rebases the beat to (0,0) before the end-of-line check runs.
      if (s_axis_tuser) begin
        sof   = 1'b1;
        cx    = '0;
        cy    = '0;
        e_sof = (state != WAIT_SOF);
      end
      if (sof || state == ACTIVE) begin
        emit    = 1'b1;
        eol     = s_axis_tlast || (cx == X_LAST);
        e_early = s_axis_tlast && (cx != X_LAST);
        if (!s_axis_tlast && cx == X_LAST) begin
          e_late  = 1'b1;
          state_n = FLUSH;
          x_n     = cx;
          y_n     = cy;
        end else if (s_axis_tlast) begin
          x_n = '0;
          if (cy == Y_LAST) begin
            done    = 1'b1;
            y_n     = '0;
            state_n = WAIT_SOF;
          end else begin
            y_n     = cy + CNT_ONE;
            state_n = ACTIVE;
          end
        end else begin
          x_n     = cx + CNT_ONE;
          y_n     = cy;
          state_n = ACTIVE;
        end
      end else begin
        drop = 1'b1;
        if (state == FLUSH && s_axis_tlast) begin
          x_n = '0;
          if (y == Y_LAST) begin
            done    = 1'b1;
            y_n     = '0;
            state_n = WAIT_SOF;
          end else begin
            y_n     = y + CNT_ONE;
            state_n = ACTIVE;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= WAIT_SOF;
      x          <= '0;
      y          <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      pix_valid  <= emit;
      pix_sof    <= sof && emit;
      pix_eol    <= eol;
      frame_done <= done;
      if (emit) begin
        pix_data <= s_axis_tdata;
        pix_x    <= cx;
        pix_y    <= cy;
      end
    end
  end

  // Clear and a same-cycle event: the event wins, so counts restart at 1.
  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_count   <= '0;
      drop_count    <= '0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
      err_sof_early <= 1'b0;
      err_keep      <= 1'b0;
    end else begin
      err_eol_early <= (err_eol_early && !clear) || e_early;
      err_eol_late  <= (err_eol_late  && !clear) || e_late;
      err_sof_early <= (err_sof_early && !clear) || e_sof;
      err_keep      <= (err_keep      && !clear) || e_keep;
      if (clear)
        frame_count <= COUNT_W'(done);
      else if (done)
        frame_count <= frame_count + COUNT_W'(1);
      if (clear)
        drop_count <= COUNT_W'(drop);
      else if (drop && drop_count != COUNT_MAX)
        drop_count <= drop_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_video_sink.sv
// tb/tb_axis_video_sink.sv - scoreboard bench for axis_video_sink at 4x2 geometry
module tb_axis_video_sink;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_axis_tvalid;
  logic [23:0] s_axis_tdata;
  logic [2:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic        throttle_en;
  logic [7:0]  throttle_pattern;
  logic        clear;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [3:0]  pix_x, pix_y;
  logic        pix_sof, pix_eol, frame_done;
  logic [15:0] frame_count, drop_count;
  logic        err_eol_early, err_eol_late, err_sof_early, err_keep;

  axis_video_sink #(.DATA_W(24), .H_ACTIVE(4), .V_ACTIVE(2), .CNT_W(4)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .throttle_en(throttle_en), .throttle_pattern(throttle_pattern), .clear(clear),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .frame_count(frame_count), .drop_count(drop_count),
    .err_eol_early(err_eol_early), .err_eol_late(err_eol_late),
    .err_sof_early(err_sof_early), .err_keep(err_keep)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [23:0] d;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        sof;
    logic        eol;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per accepted-pixel strobe.
  always @(negedge aclk) begin
    if (!areset) begin
      if (frame_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (pix_valid) begin
        exp_t got, want;
        got = {pix_data, pix_x, pix_y, pix_sof, pix_eol, frame_done};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pix_unexpected actual=%0h required=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL pix actual=%0h required=%0h", got, want);
          end
        end
      end
    end
  end

  task automatic beat(input logic [23:0] d, input logic u, input logic l, input logic [2:0] k,
                      input logic em, input logic [3:0] ex, input logic [3:0] ey,
                      input logic es, input logic ee, input logic ed);
    bit got;
    exp_t e;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tkeep  = k;
    if (em) begin
      e = '{d: d, x: ex, y: ey, sof: es, eol: ee, done: ed};
      exp_q.push_back(e);
    end
    got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      if (s_axis_tready) begin
        @(posedge aclk);
        got = 1'b1;
      end
      @(negedge aclk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=0 required=1");
    end
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge aclk);
    @(negedge aclk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
  endtask

  task automatic clean_frame(input logic [23:0] base);
    for (int i = 0; i < 8; i++)
      beat(base + 24'(i), i == 0, i == 3 || i == 7, 3'b111, 1'b1,
           4'(i % 4), 4'(i / 4), i == 0, i == 3 || i == 7, i == 7);
    idle();
    drain();
  endtask

  int t0, d0, prev;

  initial begin
    areset = 1'b1;
    clear = 1'b0;
    throttle_en = 1'b0;
    throttle_pattern = 8'h00;
    s_axis_tdata = '0;
    s_axis_tkeep = 3'b111;
    idle();
    repeat (3) @(negedge aclk);
    check("reset_tready", s_axis_tready, 0);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_counts", {frame_count, drop_count}, 0);
    check("reset_errs", {err_eol_early, err_eol_late, err_sof_early, err_keep}, 0);
    areset = 1'b0;
    @(negedge aclk);

    // Clean frame, throttle off.
    clean_frame(24'h000001);
    check("s1_frame_count", frame_count, 1);
    check("s1_errs", {err_eol_early, err_eol_late, err_sof_early, err_keep}, 0);
    check("s1_done_cnt", done_cnt, 1);

    // Throttle latency and alternation.
    check("thr_before", s_axis_tready, 1);
    throttle_en = 1'b1;
    throttle_pattern = 8'h00;
    @(negedge aclk);
    check("thr_latency", s_axis_tready, 0);
    throttle_pattern = 8'b1010_1010;
    @(negedge aclk);
    prev = s_axis_tready;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("thr_alternate", s_axis_tready, 32'(prev == 0));
      prev = s_axis_tready;
    end
    t0 = cyc;
    clean_frame(24'h000001);
    checks++;
    if (last_done_cyc - t0 < 15 || last_done_cyc - t0 > 17) begin
      errors++;
      $display("FAIL thr_frame_cycles actual=%0d required=15..17", last_done_cyc - t0);
    end
    check("thr_frame_count", frame_count, 2);
    throttle_en = 1'b0;
    @(negedge aclk);

    // Pre-SOF garbage.
    pulse_clear();
    for (int i = 0; i < 3; i++) beat(24'hAA0000 + 24'(i), 0, 0, 3'b111, 0, 0, 0, 0, 0, 0);
    clean_frame(24'h000101);
    check("s3_drop", drop_count, 3);
    check("s3_frame_count", frame_count, 1);

    // Early then late EOL.
    pulse_clear();
    beat(24'h11, 1, 0, 3'b111, 1, 0, 0, 1, 0, 0);
    beat(24'h12, 0, 1, 3'b111, 1, 1, 0, 0, 1, 0);
    check("s4_early", {err_eol_early, err_eol_late}, 2'b10);
    beat(24'h13, 0, 0, 3'b111, 1, 0, 1, 0, 0, 0);
    beat(24'h14, 0, 0, 3'b111, 1, 1, 1, 0, 0, 0);
    beat(24'h15, 0, 0, 3'b111, 1, 2, 1, 0, 0, 0);
    beat(24'h16, 0, 0, 3'b111, 1, 3, 1, 0, 1, 0);
    check("s4_late", err_eol_late, 1);
    d0 = done_cnt;
    beat(24'h17, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0);
    beat(24'h18, 0, 1, 3'b111, 0, 0, 0, 0, 0, 0);
    idle();
    drain();
    check("s4_drop", drop_count, 2);
    check("s4_frame_count", frame_count, 1);
    check("s4_flush_done", done_cnt - d0, 1);
    check("s4_no_sof_err", err_sof_early, 0);

    // Mid-frame SOF, keep error, then clear.
    pulse_clear();
    beat(24'h21, 1, 0, 3'b111, 1, 0, 0, 1, 0, 0);
    beat(24'h22, 0, 0, 3'b111, 1, 1, 0, 0, 0, 0);
    beat(24'h23, 0, 0, 3'b111, 1, 2, 0, 0, 0, 0);
    beat(24'h24, 0, 1, 3'b111, 1, 3, 0, 0, 1, 0);
    beat(24'h25, 0, 0, 3'b111, 1, 0, 1, 0, 0, 0);
    beat(24'h26, 1, 0, 3'b111, 1, 0, 0, 1, 0, 0);
    check("s5_sof_early", err_sof_early, 1);
    beat(24'h27, 0, 0, 3'b011, 1, 1, 0, 0, 0, 0);
    check("s5_keep", err_keep, 1);
    beat(24'h28, 0, 0, 3'b111, 1, 2, 0, 0, 0, 0);
    beat(24'h29, 0, 1, 3'b111, 1, 3, 0, 0, 1, 0);
    beat(24'h2A, 0, 0, 3'b111, 1, 0, 1, 0, 0, 0);
    beat(24'h2B, 0, 0, 3'b111, 1, 1, 1, 0, 0, 0);
    beat(24'h2C, 0, 0, 3'b111, 1, 2, 1, 0, 0, 0);
    beat(24'h2D, 0, 1, 3'b111, 1, 3, 1, 0, 1, 1);
    idle();
    drain();
    check("s5_frame_count", frame_count, 1);
    check("s5_eol_errs", {err_eol_early, err_eol_late}, 0);
    pulse_clear();
    check("s5_cleared", {frame_count, drop_count, err_eol_early, err_eol_late, err_sof_early, err_keep}, 0);

    // Reset mid-frame.
    for (int i = 0; i < 5; i++)
      beat(24'h31 + 24'(i), i == 0, i == 3, 3'b111, 1, 4'(i % 4), 4'(i / 4), i == 0, i == 3, 0);
    idle();
    drain();
    d0 = done_cnt;
    areset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check("rst_tready", s_axis_tready, 0);
      check("rst_pix_valid", pix_valid, 0);
    end
    areset = 1'b0;
    @(negedge aclk);
    check("rst_no_done", done_cnt - d0, 0);
    clean_frame(24'h000041);
    check("rst_frame_count", frame_count, 1);
    check("rst_done_cnt", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
